// File: rtl/core88_mem_responder_if.sv
// rtl/core88_mem_responder_if.sv - core88 byte bus between core (master) and memory responder (slave)
interface core88_mem_responder_if;
  logic [19:0] address;
  logic [7:0]  wdata;
  logic        wreq;
  logic [7:0]  rdata;
  logic        locked;

  modport master (
    output address,
    output wdata,
    output wreq,
    input  rdata,
    input  locked
  );

  modport slave (
    input  address,
    input  wdata,
    input  wreq,
    output rdata,
    output locked
  );
endinterface

// File: rtl/core88_mem_responder.sv
// rtl/core88_mem_responder.sv - core88 bus responder backed by 16-bit async SRAM with one-word read buffer
module core88_mem_responder #(
  parameter int unsigned  WAIT_CYCLES = 1,
  parameter logic [19:0]  ROM_BASE    = 20'hF0000,
  parameter bit           ROM_PROTECT = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset,
  core88_mem_responder_if.slave        bus,
  output logic [18:0]                  sram_addr,
  output logic [15:0]                  sram_dq_o,
  input  logic [15:0]                  sram_dq_i,
  output logic                         sram_oe,
  output logic                         sram_we,
  output logic                         sram_ub,
  output logic                         sram_lb
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state;
  state_t      state_next;
  logic [3:0]  counter;
  logic [15:0] buf_data;
  logic [18:0] buf_tag;
  logic        buf_valid;
  logic        op_write;
  logic        op_blocked;
  logic        op_hi;
  logic [7:0]  op_wdata;
  logic        hit;
  logic        blocked;
  logic        start;
  logic        last;
  logic        locked_int;

  // A read of the buffered word can be answered without touching the SRAM.
  assign hit = !bus.wreq && buf_valid && (buf_tag == bus.address[19:1]);

  // Writes into the BIOS region are acknowledged but never strobed.
  assign blocked = ROM_PROTECT && (bus.address >= ROM_BASE);

  assign bus.locked = locked_int;
  assign bus.rdata  = bus.address[0] ? buf_data[15:8] : buf_data[7:0];
  assign sram_dq_o  = {op_wdata, op_wdata};

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the core's advance-enable.
  always_comb begin
    state_next = state;
    locked_int = 1'b0;
    start      = 1'b0;
    last       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hit) begin
          locked_int = 1'b1;
        end else begin
          start      = 1'b1;
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (counter == 4'd0) begin
          last       = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        locked_int = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // SRAM strobes: set on entry to ACCESS, held stable, dropped on entry to DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      sram_addr <= 19'd0;
      sram_oe   <= 1'b0;
      sram_we   <= 1'b0;
      sram_ub   <= 1'b0;
      sram_lb   <= 1'b0;
    end else if (start) begin
      sram_addr <= bus.address[19:1];
      if (!bus.wreq) begin
        sram_oe <= 1'b1;
        sram_we <= 1'b0;
        sram_ub <= 1'b1;
        sram_lb <= 1'b1;
      end else begin
        sram_oe <= 1'b0;
        sram_we <= !blocked;
        sram_ub <= !blocked && bus.address[0];
        sram_lb <= !blocked && !bus.address[0];
      end
    end else if (last) begin
      sram_oe <= 1'b0;
      sram_we <= 1'b0;
      sram_ub <= 1'b0;
      sram_lb <= 1'b0;
    end
  end

  // Access counter plus the parts of the request remembered for the last ACCESS cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter    <= 4'd0;
      op_write   <= 1'b0;
      op_blocked <= 1'b0;
      op_hi      <= 1'b0;
      op_wdata   <= 8'd0;
    end else if (start) begin
      counter    <= WAIT_INIT;
      op_write   <= bus.wreq;
      op_blocked <= blocked;
      op_hi      <= bus.address[0];
      op_wdata   <= bus.wdata;
    end else if ((state == ST_ACCESS) && (counter != 4'd0)) begin
      counter <= counter - 4'd1;
    end
  end

  // Read buffer: filled by read misses, patched by unblocked writes to the same word.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_tag   <= 19'd0;
      buf_data  <= 16'd0;
    end else if (last) begin
      if (!op_write) begin
        buf_data  <= sram_dq_i;
        buf_tag   <= sram_addr;
        buf_valid <= 1'b1;
      end else if (!op_blocked && buf_valid && (buf_tag == sram_addr)) begin
        if (op_hi) begin
          buf_data[15:8] <= op_wdata;
        end else begin
          buf_data[7:0] <= op_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_core88_mem_responder.sv
// tb/tb_core88_mem_responder.sv - randomized self-checking bench for core88_mem_responder
module tb_core88_mem_responder;
  localparam int          WAIT     = 1;
  localparam int          MISS_LAT = WAIT + 2;
  localparam logic [19:0] ROM_BASE = 20'hF0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [18:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i = 16'hDEAD;
  logic        sram_oe, sram_we, sram_ub, sram_lb;

  int checks   = 0;
  int failures = 0;

  logic [15:0] sram_mem [int];
  logic [7:0]  golden   [int];
  bit          mbuf_valid = 1'b0;
  logic [18:0] mbuf_tag   = '0;

  core88_mem_responder_if bus();

  core88_mem_responder #(
    .WAIT_CYCLES (WAIT),
    .ROM_BASE    (ROM_BASE),
    .ROM_PROTECT (1'b1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .sram_addr (sram_addr),
    .sram_dq_o (sram_dq_o),
    .sram_dq_i (sram_dq_i),
    .sram_oe   (sram_oe),
    .sram_we   (sram_we),
    .sram_ub   (sram_ub),
    .sram_lb   (sram_lb)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] init_word(input logic [18:0] w);
    if (w == 19'h00008) return 16'hBEEF;
    return {w[7:0] ^ 8'h96, w[10:3] ^ 8'h3C};
  endfunction

  function automatic logic [15:0] sram_word(input logic [18:0] w);
    if (sram_mem.exists(int'(w))) return sram_mem[int'(w)];
    return init_word(w);
  endfunction

  function automatic logic [7:0] golden_byte(input logic [19:0] a);
    logic [15:0] w;
    if (golden.exists(int'(a))) return golden[int'(a)];
    w = init_word(a[19:1]);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  // Asynchronous SRAM: data presented while output-enabled, lanes written while write-enabled.
  always @(negedge clock) sram_dq_i = sram_oe ? sram_word(sram_addr) : 16'hDEAD;

  always @(posedge clock) begin
    logic [15:0] w;
    if (sram_we) begin
      w = sram_word(sram_addr);
      if (sram_ub) w[15:8] = sram_dq_o[15:8];
      if (sram_lb) w[7:0]  = sram_dq_o[7:0];
      sram_mem[int'(sram_addr)] = w;
    end
  end

  // Reference: byte memory with ROM protection, and a one-word buffer filled only by read misses.
  task automatic model_op(input logic [19:0] a, input logic w, input logic [7:0] d,
                          output int e_lat, output logic [7:0] e_rd, output int e_we);
    bit is_hit;
    e_rd = golden_byte(a);
    e_we = 0;
    if (!w) begin
      is_hit = mbuf_valid && (mbuf_tag == a[19:1]);
      e_lat  = is_hit ? 0 : MISS_LAT;
      if (!is_hit) begin
        mbuf_valid = 1'b1;
        mbuf_tag   = a[19:1];
      end
    end else begin
      e_lat = MISS_LAT;
      if (a < ROM_BASE) begin
        e_we = WAIT + 1;
        golden[int'(a)] = d;
      end
    end
  endtask

  // Core-side driver: present one request and wait for the advance edge.
  task automatic bus_op(input logic [19:0] a, input logic w, input logic [7:0] d,
                        output int lat, output logic [7:0] rd, output int oe_c, output int we_c,
                        output int we_b, output logic ub_s, output logic lb_s,
                        output logic [15:0] dq_s, output logic [18:0] addr_s, output bit to);
    logic prev_we = 1'b0;
    bit   done    = 1'b0;
    bus.address = a;
    bus.wreq    = w;
    bus.wdata   = d;
    lat = 0; rd = '0; oe_c = 0; we_c = 0; we_b = 0;
    ub_s = 1'b0; lb_s = 1'b0; dq_s = '0; addr_s = '0; to = 1'b0;
    while (!done) begin
      @(negedge clock);
      if (sram_oe) oe_c++;
      if (sram_we) begin
        we_c++;
        if (!prev_we) we_b++;
      end
      prev_we = sram_we;
      if (sram_oe || sram_we || sram_ub || sram_lb) begin
        ub_s = sram_ub; lb_s = sram_lb; dq_s = sram_dq_o; addr_s = sram_addr;
      end
      if (bus.locked) begin
        rd   = bus.rdata;
        done = 1'b1;
      end else begin
        lat++;
        if (lat > 50) begin
          to   = 1'b1;
          done = 1'b1;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.address = 20'h00010;
    bus.wreq    = 1'b0;
    bus.wdata   = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", bus.locked); end
    checks++; if ({sram_oe, sram_we, sram_ub, sram_lb} !== 4'b0000) begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {sram_oe, sram_we, sram_ub, sram_lb}); end
    checks++; if (sram_addr !== 19'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    mbuf_valid = 1'b0;
  endtask

  task automatic test_read_miss_hit();
    int lat, oe_c, we_c, we_b, e_lat, e_we; logic [7:0] rd, e_rd;
    logic ub, lb; logic [15:0] dq; logic [18:0] sa; bit to;
    model_op(20'h00010, 1'b0, 8'h00, e_lat, e_rd, e_we);
    bus_op(20'h00010, 1'b0, 8'h00, lat, rd, oe_c, we_c, we_b, ub, lb, dq, sa, to);
    checks++; if (to || lat !== 3 || lat !== e_lat) begin failures++; $display("FAIL miss_latency got=%0d exp=3 timeout=%b", lat, to); end
    checks++; if (rd !== 8'hEF || rd !== e_rd) begin failures++; $display("FAIL miss_rdata got=%h exp=ef", rd); end
    checks++; if (oe_c !== 2) begin failures++; $display("FAIL miss_oe_cycles got=%0d exp=2", oe_c); end
    checks++; if (sa !== 19'h00008) begin failures++; $display("FAIL miss_sram_addr got=%h exp=00008", sa); end
    model_op(20'h00011, 1'b0, 8'h00, e_lat, e_rd, e_we);
    bus_op(20'h00011, 1'b0, 8'h00, lat, rd, oe_c, we_c, we_b, ub, lb, dq, sa, to);
    checks++; if (to || lat !== 0) begin failures++; $display("FAIL hit_latency got=%0d exp=0", lat); end
    checks++; if (rd !== 8'hBE) begin failures++; $display("FAIL hit_rdata got=%h exp=be", rd); end
    checks++; if (oe_c !== 0) begin failures++; $display("FAIL hit_oe_cycles got=%0d exp=0", oe_c); end
  endtask

  task automatic test_write_coherent();
    int lat, oe_c, we_c, we_b, e_lat, e_we; logic [7:0] rd, e_rd;
    logic ub, lb; logic [15:0] dq; logic [18:0] sa; bit to;
    model_op(20'h00011, 1'b1, 8'h5A, e_lat, e_rd, e_we);
    bus_op(20'h00011, 1'b1, 8'h5A, lat, rd, oe_c, we_c, we_b, ub, lb, dq, sa, to);
    checks++; if (to || lat !== e_lat) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", lat, e_lat); end
    checks++; if (we_c !== 2 || we_b !== 1) begin failures++; $display("FAIL wr_we got=%0d/%0d exp=2/1", we_c, we_b); end
    checks++; if ({ub, lb} !== 2'b10 || dq !== 16'h5A5A) begin failures++; $display("FAIL wr_lanes got=%b%b dq=%h exp=10 5a5a", ub, lb, dq); end
    model_op(20'h00011, 1'b0, 8'h00, e_lat, e_rd, e_we);
    bus_op(20'h00011, 1'b0, 8'h00, lat, rd, oe_c, we_c, we_b, ub, lb, dq, sa, to);
    checks++; if (to || lat !== 0) begin failures++; $display("FAIL wr_then_hit_latency got=%0d exp=0", lat); end
    checks++; if (rd !== 8'h5A) begin failures++; $display("FAIL wr_then_hit_rdata got=%h exp=5a", rd); end
  endtask

  task automatic test_rom_protect();
    int lat, oe_c, we_c, we_b, e_lat, e_we; logic [7:0] rd, e_rd;
    logic ub, lb; logic [15:0] dq; logic [18:0] sa; bit to;
    model_op(20'hFFFF0, 1'b1, 8'h12, e_lat, e_rd, e_we);
    bus_op(20'hFFFF0, 1'b1, 8'h12, lat, rd, oe_c, we_c, we_b, ub, lb, dq, sa, to);
    checks++; if (to || lat !== 3) begin failures++; $display("FAIL rom_wr_latency got=%0d exp=3", lat); end
    checks++; if (we_c !== 0 || {ub, lb} !== 2'b00) begin failures++; $display("FAIL rom_wr_strobes got=we%0d ub%b lb%b exp=none", we_c, ub, lb); end
    model_op(20'hFFFF0, 1'b0, 8'h00, e_lat, e_rd, e_we);
    bus_op(20'hFFFF0, 1'b0, 8'h00, lat, rd, oe_c, we_c, we_b, ub, lb, dq, sa, to);
    checks++; if (to || lat !== e_lat || rd !== e_rd) begin failures++; $display("FAIL rom_readback got=%h lat=%0d exp=%h lat=%0d", rd, lat, e_rd, e_lat); end
    model_op(20'hFFFFF, 1'b0, 8'h00, e_lat, e_rd, e_we);
    bus_op(20'hFFFFF, 1'b0, 8'h00, lat, rd, oe_c, we_c, we_b, ub, lb, dq, sa, to);
    checks++; if (sa !== 19'h7FFFF || rd !== e_rd) begin failures++; $display("FAIL wrap_read got=%h/%h exp=7ffff/%h", sa, rd, e_rd); end
  endtask

  task automatic test_back_to_back();
    int lat, oe_c, we_c, we_b, e_lat, e_we; logic [7:0] rd, e_rd;
    logic ub, lb; logic [15:0] dq; logic [18:0] sa; bit to;
    logic [7:0] vals [2];
    vals[0] = 8'h11;
    vals[1] = 8'h22;
    for (int i = 0; i < 2; i++) begin
      model_op(20'h00020, 1'b1, vals[i], e_lat, e_rd, e_we);
      bus_op(20'h00020, 1'b1, vals[i], lat, rd, oe_c, we_c, we_b, ub, lb, dq, sa, to);
      checks++; if (to || lat !== 3 || we_b !== 1 || we_c !== 2) begin failures++; $display("FAIL b2b_write%0d got=lat%0d bursts%0d we%0d exp=3/1/2", i, lat, we_b, we_c); end
    end
    model_op(20'h00020, 1'b0, 8'h00, e_lat, e_rd, e_we);
    bus_op(20'h00020, 1'b0, 8'h00, lat, rd, oe_c, we_c, we_b, ub, lb, dq, sa, to);
    checks++; if (rd !== 8'h22 || lat !== e_lat) begin failures++; $display("FAIL b2b_readback got=%h lat=%0d exp=22 lat=%0d", rd, lat, e_lat); end
  endtask

  task automatic test_reset_abort();
    int lat, oe_c, we_c, we_b, e_lat, e_we; logic [7:0] rd, e_rd;
    logic ub, lb; logic [15:0] dq; logic [18:0] sa; bit to;
    bit saw_lock = 1'b0;
    bus.address = 20'h00030;
    bus.wreq    = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    checks++; if (sram_oe !== 1'b1) begin failures++; $display("FAIL abort_in_access got=oe%b exp=1", sram_oe); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (bus.locked) saw_lock = 1'b1;
      if (i == 0) begin
        checks++; if (sram_oe !== 1'b0 || sram_we !== 1'b0) begin failures++; $display("FAIL abort_strobes got=oe%b we%b exp=0", sram_oe, sram_we); end
      end
    end
    checks++; if (saw_lock) begin failures++; $display("FAIL abort_locked got=1 exp=0"); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    mbuf_valid = 1'b0;
    model_op(20'h00030, 1'b0, 8'h00, e_lat, e_rd, e_we);
    bus_op(20'h00030, 1'b0, 8'h00, lat, rd, oe_c, we_c, we_b, ub, lb, dq, sa, to);
    checks++; if (to || lat !== 3 || oe_c !== 2 || rd !== e_rd) begin failures++; $display("FAIL abort_remiss got=lat%0d oe%0d rd%h exp=3/2/%h", lat, oe_c, rd, e_rd); end
  endtask

  task automatic test_random();
    int lat, oe_c, we_c, we_b, e_lat, e_we; logic [7:0] rd, e_rd;
    logic ub, lb; logic [15:0] dq; logic [18:0] sa; bit to;
    logic [19:0] a; logic w; logic [7:0] d; int kind;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5)      a = 20'h00040 + 20'($urandom_range(0, 15));
      else if (kind <= 7) a = 20'($urandom);
      else if (kind == 8) a = ROM_BASE + 20'($urandom_range(0, 65535));
      else                a = 20'hFFFFE + 20'($urandom_range(0, 1));
      w = ($urandom_range(0, 2) == 0);
      d = 8'($urandom);
      model_op(a, w, d, e_lat, e_rd, e_we);
      bus_op(a, w, d, lat, rd, oe_c, we_c, we_b, ub, lb, dq, sa, to);
      checks++; if (to || lat !== e_lat) begin failures++; $display("FAIL rnd_latency op=%0d a=%h w=%b got=%0d exp=%0d", n, a, w, lat, e_lat); end
      if (!w) begin
        checks++; if (rd !== e_rd) begin failures++; $display("FAIL rnd_rdata op=%0d a=%h got=%h exp=%h", n, a, rd, e_rd); end
      end else begin
        checks++; if (we_c !== e_we) begin failures++; $display("FAIL rnd_we op=%0d a=%h got=%0d exp=%0d", n, a, we_c, e_we); end
        if (e_we != 0) begin
          checks++; if (ub !== a[0] || lb !== !a[0] || sa !== a[19:1] || dq !== {d, d}) begin failures++; $display("FAIL rnd_lanes op=%0d a=%h got=%b%b %h %h", n, a, ub, lb, sa, dq); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_coherent();
    test_rom_protect();
    test_back_to_back();
    test_reset_abort();
    test_random();
    bus.wreq = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
